// File: rtl/crc8_pkg.sv
// Shared types and constants for the CRC8 frame sequencer and its byte serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package crc8_pkg;

    // Seed value of the external CRC8 engine after a clear pulse.
    localparam logic [7:0] CRC8_RESET_VALUE = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SEND,
        WAIT_DONE,
        REPORT
    } crc8_seq_state_t;

    typedef struct packed {
        logic       match;
        logic       timeout;
        logic [7:0] crc;
    } crc8_result_t;

endpackage

// File: rtl/crc8_frame_sequencer_if.sv
// Bundle of the frame-request, CRC-engine and result ports of the CRC8 frame sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready for frames, res_valid/res_ready for results; engine side has none.
// Modports: slave = sequencer view, master = environment view (receive path, engine, result sink).
interface crc8_frame_sequencer_if #(
    parameter int DATA_LENGTH = 32
);
    // frame request
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_LENGTH-1:0] in_payload;
    logic [7:0]             in_crc;
    // CRC engine
    logic                   crc_clear;
    logic                   crc_valid;
    logic                   crc_last;
    logic [7:0]             crc_data;
    logic                   crc_done;
    logic                   crc_match;
    logic [7:0]             crc_value;
    // result
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_match;
    logic                   res_timeout;
    logic [7:0]             res_crc;
    // status
    logic                   busy;

    modport slave (
        input  in_valid, in_payload, in_crc,
        input  crc_done, crc_match, crc_value,
        input  res_ready,
        output in_ready,
        output crc_clear, crc_valid, crc_last, crc_data,
        output res_valid, res_match, res_timeout, res_crc,
        output busy
    );

    modport master (
        output in_valid, in_payload, in_crc,
        output crc_done, crc_match, crc_value,
        output res_ready,
        input  in_ready,
        input  crc_clear, crc_valid, crc_last, crc_data,
        input  res_valid, res_match, res_timeout, res_crc,
        input  busy
    );

endinterface

// File: rtl/crc8_byte_serializer.sv
// Holds a latched payload + CRC byte and presents them one byte per advance, payload MSB byte first, CRC byte last.
// Latency: byte k visible k advances after load; data/last are decoded from registers only.
// Backpressure: none; the caller advances only while the engine is being fed.
// Ports: load latches payload/crc and rewinds the counter; advance steps one byte; data = current byte; last = CRC byte is current.
module crc8_byte_serializer #(
    parameter int DATA_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_LENGTH-1:0] payload,
    input  logic [7:0]             crc,
    input  logic                   advance,
    output logic [7:0]             data,
    output logic                   last
);
    localparam int DATA_LENGTH_BYTES = DATA_LENGTH / 8;
    localparam int CNT_W             = $clog2(DATA_LENGTH_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_CRC = CNT_W'(DATA_LENGTH_BYTES);

    logic [DATA_LENGTH-1:0] shift_q;
    logic [7:0]             crc_q;
    logic [CNT_W-1:0]       cnt_q;

    // The payload is shifted up one byte per advance, so the byte to send is always the top byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= payload;
            crc_q   <= crc;
            cnt_q   <= '0;
        end else if (advance && !last) begin
            shift_q <= shift_q << 8;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign last = (cnt_q == CNT_CRC);
    assign data = last ? crc_q : shift_q[DATA_LENGTH-1 -: 8];

endmodule

// File: rtl/crc8_frame_sequencer.sv
// Sequences one frame through an external CRC8 engine: clear, payload bytes, CRC byte with last, then wait for done.
// Latency: result valid 3 + DATA_LENGTH/8 + (engine done delay) cycles after accept; TIMEOUT_CYCLES waiting cycles at most.
// Backpressure: in_ready only in IDLE; result held in REPORT until res_ready, no new frame in the handshake cycle.
// Ports: clk, reset (async active-low); bus.slave carries the frame request, engine strobes/status, result and busy.
module crc8_frame_sequencer
    import crc8_pkg::*;
#(
    parameter int DATA_LENGTH    = 32,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    crc8_frame_sequencer_if.slave bus
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    crc8_seq_state_t    state_q;
    crc8_seq_state_t    state_d;
    logic [TIMER_W-1:0] timer_q;
    crc8_result_t       result_q;

    logic               accept;
    logic               timer_expired;
    logic [7:0]         ser_data;
    logic               ser_last;

    assign accept        = (state_q == IDLE) && bus.in_valid;
    assign timer_expired = (timer_q == TIMER_LAST);

    crc8_byte_serializer #(
        .DATA_LENGTH (DATA_LENGTH)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .payload (bus.in_payload),
        .crc     (bus.in_crc),
        .advance (state_q == SEND),
        .data    (ser_data),
        .last    (ser_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts cycles spent in WAIT_DONE; held at zero elsewhere so every wait starts fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (state_q == WAIT_DONE) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    // Done is checked before the timer so a done landing on the last wait cycle still reports a match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (state_q == WAIT_DONE && bus.crc_done) begin
            result_q.match   <= bus.crc_match;
            result_q.timeout <= 1'b0;
            result_q.crc     <= bus.crc_value;
        end else if (state_q == WAIT_DONE && timer_expired) begin
            result_q.match   <= 1'b0;
            result_q.timeout <= 1'b1;
            result_q.crc     <= bus.crc_value;
        end else if (state_q == REPORT && bus.res_ready) begin
            result_q <= '0;
        end
    end

    // Next state and outputs; every output is decoded from registered state only.
    always_comb begin
        state_d         = state_q;
        bus.in_ready    = 1'b0;
        bus.busy        = 1'b1;
        bus.crc_clear   = 1'b0;
        bus.crc_valid   = 1'b0;
        bus.crc_last    = 1'b0;
        bus.crc_data    = 8'h00;
        bus.res_valid   = 1'b0;
        bus.res_match   = result_q.match;
        bus.res_timeout = result_q.timeout;
        bus.res_crc     = result_q.crc;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                bus.crc_clear = 1'b1;
                state_d       = SEND;
            end
            SEND: begin
                bus.crc_valid = 1'b1;
                bus.crc_data  = ser_data;
                bus.crc_last  = ser_last;
                if (ser_last) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.crc_done || timer_expired) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_crc8_frame_sequencer.sv
module tb_crc8_frame_sequencer;
    import crc8_pkg::*;

    localparam int DL = 32;
    localparam int NB = DL / 8;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    crc8_frame_sequencer_if #(.DATA_LENGTH(DL)) bus();

    crc8_frame_sequencer #(
        .DATA_LENGTH    (DL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;
    int last_accept = 0;
    int exp_next_period = 0;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Byte k of the payload in transmission order (k=0 is the most significant byte).
    function automatic logic [7:0] ref_byte(input logic [31:0] p, input int k);
        return 8'((p >> (8 * (NB - 1 - k))) & 32'hFF);
    endfunction

    function automatic logic [7:0] ref_crc(input logic [31:0] p);
        logic [7:0] c;
        c = 8'h0D;
        for (int k = 0; k < NB; k++) c = crc8_step(c, ref_byte(p, k));
        return c;
    endfunction

    // Timeline: accept, CLEAR, NB+1 SEND cycles, then done d cycles after the last byte (1..TO) or TO wait cycles.
    function automatic void ref_result(input logic [31:0] p, input logic [7:0] cb, input int delay,
                                       output logic m, output logic t, output int lat);
        if (delay >= 1 && delay <= TO) begin
            m = (cb == ref_crc(p)); t = 1'b0; lat = 3 + NB + delay;
        end else begin
            m = 1'b0; t = 1'b1; lat = 3 + NB + TO;
        end
    endfunction

    // ---------------- CRC engine stub ----------------
    logic [7:0] eng_crc;
    logic       eng_match_q;
    int         eng_dcnt;
    int         eng_delay = 1;   // cycles from last byte to done; 0 = never
    logic       force_done = 1'b0;
    logic       force_match = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_crc     <= CRC8_RESET_VALUE;
            eng_match_q <= 1'b0;
            eng_dcnt    <= 0;
        end else begin
            if (eng_dcnt != 0) eng_dcnt <= eng_dcnt - 1;
            if (bus.crc_clear) begin
                eng_crc  <= CRC8_RESET_VALUE;
                eng_dcnt <= 0;
            end else if (bus.crc_valid) begin
                if (bus.crc_last) begin
                    eng_match_q <= (bus.crc_data == eng_crc);
                    eng_dcnt    <= eng_delay;
                end else begin
                    eng_crc <= crc8_step(eng_crc, bus.crc_data);
                end
            end
        end
    end

    assign bus.crc_done  = (eng_dcnt == 1) || force_done;
    assign bus.crc_match = force_done ? force_match : eng_match_q;
    assign bus.crc_value = eng_crc;

    // ---------------- tasks ----------------
    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},    bus.in_ready, 1);
        check({tag, " busy"},        bus.busy, 0);
        check({tag, " crc_clear"},   bus.crc_clear, 0);
        check({tag, " crc_valid"},   bus.crc_valid, 0);
        check({tag, " crc_last"},    bus.crc_last, 0);
        check({tag, " crc_data"},    bus.crc_data, 0);
        check({tag, " res_valid"},   bus.res_valid, 0);
        check({tag, " res_match"},   bus.res_match, 0);
        check({tag, " res_timeout"}, bus.res_timeout, 0);
        check({tag, " res_crc"},     bus.res_crc, 0);
    endtask

    task automatic do_frame(input string tag, input logic [31:0] pay, input logic [7:0] cb,
                            input int delay, input int bp,
                            input logic exp_m, input logic exp_t, input int exp_lat);
        int n, cyc, nbytes, clears, first_v, last_v, bad_last, bad_byte, accept_cycle;
        logic [7:0] exp_c, exp_b;
        exp_c = ref_crc(pay);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready before accept"}, bus.in_ready, 1);
        accept_cycle = cycle_no;
        if (exp_next_period > 0)
            check({tag, " frame period"}, accept_cycle - last_accept, exp_next_period);
        eng_delay      = delay;
        bus.res_ready  = (bp == 0);
        bus.in_payload = pay;
        bus.in_crc     = cb;
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1; nbytes = 0; clears = 0; first_v = -1; last_v = -1; bad_last = 0; bad_byte = 0;
        while (bus.res_valid !== 1'b1 && cyc < 40) begin
            if (bus.crc_clear) clears++;
            if (bus.crc_valid) begin
                if (first_v < 0) first_v = cyc;
                if (nbytes <= NB) begin
                    exp_b = (nbytes < NB) ? ref_byte(pay, nbytes) : cb;
                    if (bus.crc_data !== exp_b) bad_byte++;
                    if (bus.crc_last !== (nbytes == NB)) bad_last++;
                end
                if (bus.crc_last) last_v = cyc;
                nbytes++;
            end else if (bus.crc_last) begin
                bad_last++;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " result latency"},   cyc, exp_lat);
        check({tag, " bytes sent"},       nbytes, NB + 1);
        check({tag, " clear pulses"},     clears, 1);
        check({tag, " first byte cycle"}, first_v, 2);
        check({tag, " last byte cycle"},  last_v, 2 + NB);
        check({tag, " byte errors"},      bad_byte, 0);
        check({tag, " last errors"},      bad_last, 0);
        check({tag, " res_match"},        bus.res_match, exp_m);
        check({tag, " res_timeout"},      bus.res_timeout, exp_t);
        check({tag, " res_crc"},          bus.res_crc, exp_c);
        check({tag, " in_ready in report"}, bus.in_ready, 0);
        // Hold the result back; stray done/match and frame requests must not disturb it.
        for (int i = 0; i < bp; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_payload = ~pay;
            force_done     = 1'b1;
            force_match    = ~exp_m;
            @(negedge clk);
            check({tag, " bp res_valid"},   bus.res_valid, 1);
            check({tag, " bp in_ready"},    bus.in_ready, 0);
            check({tag, " bp res_match"},   bus.res_match, exp_m);
            check({tag, " bp res_timeout"}, bus.res_timeout, exp_t);
            check({tag, " bp res_crc"},     bus.res_crc, exp_c);
            check({tag, " bp crc_valid"},   bus.crc_valid, 0);
        end
        bus.in_valid  = 1'b0;
        force_done    = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check({tag, " res_valid after handshake"}, bus.res_valid, 0);
        check({tag, " in_ready after handshake"},  bus.in_ready, 1);
        check({tag, " busy after handshake"},      bus.busy, 0);
        last_accept     = accept_cycle;
        exp_next_period = exp_lat + bp + 1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] pay;
        logic [7:0]  crc_xor;
        int          delay;
        int          bp;
        logic        exp_m;
        logic        exp_t;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] p;
        logic [7:0]  cb;
        logic        m, t;
        int          d, bp, lat;

        vecs[0] = '{32'h12345678, 8'h00, 1, 0, 1'b1, 1'b0, 8};   // good frame
        vecs[1] = '{32'h12345678, 8'h01, 1, 0, 1'b0, 1'b0, 8};   // corrupted CRC
        vecs[2] = '{32'hDEADBEEF, 8'h00, 2, 5, 1'b1, 1'b0, 9};   // back-pressure 5 cycles
        vecs[3] = '{32'h00000000, 8'h00, 0, 0, 1'b0, 1'b1, 15};  // engine never done
        vecs[4] = '{32'hFFFFFFFF, 8'h00, 8, 0, 1'b1, 1'b0, 15};  // done on the timeout cycle wins
        vecs[5] = '{32'h0F0F0F0F, 8'h00, 9, 0, 1'b0, 1'b1, 15};  // done one cycle too late
        vecs[6] = '{32'hA5A5A5A5, 8'h80, 2, 2, 1'b0, 1'b0, 9};   // bad CRC under back-pressure

        bus.in_valid   = 1'b0;
        bus.in_payload = '0;
        bus.in_crc     = '0;
        bus.res_ready  = 1'b1;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("after release");

        // Engine status outside WAIT_DONE is ignored.
        force_done  = 1'b1;
        force_match = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle stray done res_valid", bus.res_valid, 0);
            check("idle stray done busy", bus.busy, 0);
        end
        force_done = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].pay, ref_crc(vecs[i].pay) ^ vecs[i].crc_xor,
                     vecs[i].delay, vecs[i].bp, vecs[i].exp_m, vecs[i].exp_t, vecs[i].exp_lat);
        end

        // Reset in the middle of SEND abandons the frame.
        exp_next_period = 0;
        eng_delay      = 1;
        bus.in_payload = 32'h11223344;
        bus.in_crc     = ref_crc(32'h11223344);
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-send byte 2", bus.crc_data, 8'h33);
        reset = 1'b0;
        #1;
        check_reset_values("mid-send reset");
        repeat (2) @(negedge clk);
        check("held reset res_valid", bus.res_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("after mid-send reset");
        do_frame("post-reset", 32'hA5A5A5A5, ref_crc(32'hA5A5A5A5), 1, 0, 1'b1, 1'b0, 8);

        // Back-to-back frames, done after 2 cycles: 10-cycle period.
        for (int i = 0; i < 4; i++) begin
            p = 32'h01020304 * (i + 1);
            do_frame($sformatf("b2b%0d", i), p, ref_crc(p), 2, 0, 1'b1, 1'b0, 9);
        end

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            p  = $urandom;
            cb = ref_crc(p);
            if ($urandom_range(0, 1) == 1) cb = cb ^ (8'h01 << $urandom_range(0, 7));
            d  = $urandom_range(0, 9);
            bp = $urandom_range(0, 3);
            ref_result(p, cb, d, m, t, lat);
            do_frame($sformatf("rnd%0d", i), p, cb, d, bp, m, t, lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
